// File: rtl/evm_ballot_controller.sv
// Booth-side ballot sequencer: releases one ballot per officer arm press, debounces
// the voter buttons and issues a single one-hot vote strobe to the EVM per ballot.
module evm_ballot_controller #(
  parameter int N_CAND      = 5,
  parameter int DEB_CYC     = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int BEEP_CYC    = 8,
  parameter int DISP_CYC    = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              close_poll,
  input  logic [N_CAND-1:0] vote_sw,
  output logic              evm_en,
  output logic [N_CAND-1:0] evm_switch,
  output logic              ballot_led,
  output logic              busy,
  output logic              beep,
  output logic              reject,
  output logic              timeout,
  output logic              poll_closed,
  output logic [2:0]        disp_sel,
  output logic [CNT_W-1:0]  total_votes
);

  localparam int CMAX_A = (TIMEOUT_CYC > BEEP_CYC) ? TIMEOUT_CYC : BEEP_CYC;
  localparam int CMAX   = (CMAX_A > DISP_CYC) ? CMAX_A : DISP_CYC;
  localparam int CW     = $clog2(CMAX);
  localparam int SW     = $clog2(DEB_CYC);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAST, S_BEEP, S_CLOSED} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       stab_cnt_q, stab_cnt_d;
  logic [N_CAND-1:0]   sw_q;
  logic [N_CAND-1:0]   cap_sw_q, cap_sw_d;
  logic                arm_q;
  logic                close_pend_q, close_pend_d;
  logic                wait_release_q, wait_release_d;
  logic [CNT_W-1:0]    total_votes_q, total_votes_d;
  logic [2:0]          disp_sel_q, disp_sel_d;
  logic                evm_en_q, evm_en_d;
  logic [N_CAND-1:0]   evm_switch_q, evm_switch_d;
  logic                ballot_led_q, ballot_led_d;
  logic                busy_q, busy_d;
  logic                beep_q, beep_d;
  logic                reject_q, reject_d;
  logic                timeout_q, timeout_d;
  logic                poll_closed_q, poll_closed_d;

  logic arm_rise;
  logic press_match;

  assign arm_rise    = arm & ~arm_q;
  assign press_match = (vote_sw == sw_q) && (vote_sw != '0);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stab_cnt_d     = '0;
    cap_sw_d       = cap_sw_q;
    close_pend_d   = close_pend_q;
    wait_release_d = wait_release_q;
    total_votes_d  = total_votes_q;
    disp_sel_d     = disp_sel_q;
    reject_d       = 1'b0;
    timeout_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (close_poll || close_pend_q) begin
          state_d      = S_CLOSED;
          close_pend_d = 1'b0;
          cnt_d        = '0;
          disp_sel_d   = '0;
        end else if (arm_rise) begin
          state_d        = S_ARMED;
          cnt_d          = '0;
          wait_release_d = 1'b0;
        end
      end
      S_ARMED: begin
        cnt_d = cnt_q + CW'(1);
        if (close_poll) close_pend_d = 1'b1;
        // After a rejected pattern nothing is evaluated until all buttons are seen released.
        if (wait_release_q) begin
          if (vote_sw == '0) wait_release_d = 1'b0;
        end else if (press_match) begin
          if (stab_cnt_q == SW'(DEB_CYC - 2)) begin
            if ($onehot(vote_sw)) begin
              cap_sw_d = vote_sw;
              state_d  = S_CAST;
            end else begin
              reject_d       = 1'b1;
              wait_release_d = 1'b1;
            end
          end else begin
            stab_cnt_d = stab_cnt_q + SW'(1);
          end
        end
        if (state_d != S_CAST && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CAST: begin
        if (close_poll) close_pend_d = 1'b1;
        if (total_votes_q != '1) total_votes_d = total_votes_q + CNT_W'(1);
        state_d = S_BEEP;
        cnt_d   = '0;
      end
      S_BEEP: begin
        if (close_poll) close_pend_d = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BEEP_CYC - 1)) state_d = S_IDLE;
      end
      S_CLOSED: begin
        if (cnt_q == CW'(DISP_CYC - 1)) begin
          cnt_d      = '0;
          disp_sel_d = (disp_sel_q == 3'(N_CAND - 1)) ? 3'd0 : disp_sel_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ballot_led_d  = (state_d == S_ARMED);
    busy_d        = (state_d == S_CAST) || (state_d == S_BEEP);
    beep_d        = (state_d == S_BEEP);
    poll_closed_d = (state_d == S_CLOSED);
    evm_en_d      = (state_d == S_CAST);
    evm_switch_d  = (state_d == S_CAST) ? cap_sw_d : '0;
  end

  // Every register, including the output flops, clears the moment reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      stab_cnt_q     <= '0;
      sw_q           <= '0;
      cap_sw_q       <= '0;
      arm_q          <= 1'b0;
      close_pend_q   <= 1'b0;
      wait_release_q <= 1'b0;
      total_votes_q  <= '0;
      disp_sel_q     <= '0;
      evm_en_q       <= 1'b0;
      evm_switch_q   <= '0;
      ballot_led_q   <= 1'b0;
      busy_q         <= 1'b0;
      beep_q         <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
      poll_closed_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stab_cnt_q     <= stab_cnt_d;
      sw_q           <= vote_sw;
      cap_sw_q       <= cap_sw_d;
      arm_q          <= arm;
      close_pend_q   <= close_pend_d;
      wait_release_q <= wait_release_d;
      total_votes_q  <= total_votes_d;
      disp_sel_q     <= disp_sel_d;
      evm_en_q       <= evm_en_d;
      evm_switch_q   <= evm_switch_d;
      ballot_led_q   <= ballot_led_d;
      busy_q         <= busy_d;
      beep_q         <= beep_d;
      reject_q       <= reject_d;
      timeout_q      <= timeout_d;
      poll_closed_q  <= poll_closed_d;
    end
  end

  assign evm_en      = evm_en_q;
  assign evm_switch  = evm_switch_q;
  assign ballot_led  = ballot_led_q;
  assign busy        = busy_q;
  assign beep        = beep_q;
  assign reject      = reject_q;
  assign timeout     = timeout_q;
  assign poll_closed = poll_closed_q;
  assign disp_sel    = disp_sel_q;
  assign total_votes = total_votes_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Bench for evm_ballot_controller: a directed vector table, directed corner sequences
// and randomized ballots, all compared cycle by cycle against a behavioural model.
module tb_evm_ballot_controller;

  localparam int N_CAND      = 5;
  localparam int DEB_CYC     = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int BEEP_CYC    = 8;
  localparam int DISP_CYC    = 16;
  localparam int CNT_W       = 16;

  localparam int P_IDLE   = 0;
  localparam int P_ARMED  = 1;
  localparam int P_CAST   = 2;
  localparam int P_BEEP   = 3;
  localparam int P_CLOSED = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arm = 1'b0;
  logic              close_poll = 1'b0;
  logic [N_CAND-1:0] vote_sw = '0;
  logic              evm_en;
  logic [N_CAND-1:0] evm_switch;
  logic              ballot_led, busy, beep, reject, timeout, poll_closed;
  logic [2:0]        disp_sel;
  logic [CNT_W-1:0]  total_votes;

  evm_ballot_controller #(
    .N_CAND(N_CAND), .DEB_CYC(DEB_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .BEEP_CYC(BEEP_CYC), .DISP_CYC(DISP_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .close_poll(close_poll), .vote_sw(vote_sw),
    .evm_en(evm_en), .evm_switch(evm_switch), .ballot_led(ballot_led), .busy(busy),
    .beep(beep), .reject(reject), .timeout(timeout), .poll_closed(poll_closed),
    .disp_sel(disp_sel), .total_votes(total_votes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int rej_count = 0;
  int to_count = 0;
  logic [N_CAND-1:0] last_cast_sw = '0;

  // Behavioural model: phase plus elapsed cycles, run length of identical presses.
  int                m_phase, m_age, m_run, m_total;
  logic [N_CAND-1:0] m_last, m_cap;
  bit                m_wait, m_pend, m_prev_arm, m_rej, m_to;

  typedef struct {
    logic              arm;
    logic [N_CAND-1:0] sw;
    logic              led;
    logic              en;
    logic [N_CAND-1:0] swo;
    logic              busy;
    logic              bp;
    logic [CNT_W-1:0]  total;
  } vec_t;

  vec_t tbl[14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_age = 0; m_run = 0; m_total = 0;
    m_last = '0; m_cap = '0;
    m_wait = 0; m_pend = 0; m_prev_arm = 0; m_rej = 0; m_to = 0;
  endtask

  task automatic model_edge();
    logic [N_CAND-1:0] v;
    bit rise;
    v = vote_sw;
    rise = arm && !m_prev_arm;
    m_rej = 0;
    m_to = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (close_poll || m_pend) begin
          m_phase = P_CLOSED; m_pend = 0; m_age = 0;
        end else if (rise) begin
          m_phase = P_ARMED; m_age = 0; m_wait = 0; m_run = (v != 0) ? 1 : 0;
        end
      end
      P_ARMED: begin
        if (close_poll) m_pend = 1;
        if (m_wait) begin
          m_run = 0;
          if (v == 0) m_wait = 0;
        end else begin
          if (v != 0 && v == m_last) m_run = m_run + 1;
          else m_run = (v != 0) ? 1 : 0;
          if (m_run == DEB_CYC) begin
            m_run = 0;
            if ($onehot(v)) begin
              m_cap = v; m_phase = P_CAST;
            end else begin
              m_rej = 1; m_wait = 1;
            end
          end
        end
        if (m_phase == P_ARMED) begin
          if (m_age == TIMEOUT_CYC - 1) begin
            m_to = 1; m_phase = P_IDLE;
          end else begin
            m_age++;
          end
        end
      end
      P_CAST: begin
        if (close_poll) m_pend = 1;
        if (m_total < (1 << CNT_W) - 1) m_total++;
        m_phase = P_BEEP; m_age = 0;
      end
      P_BEEP: begin
        if (close_poll) m_pend = 1;
        if (m_age == BEEP_CYC - 1) m_phase = P_IDLE;
        else m_age++;
      end
      default: m_age++;
    endcase
    m_last = v;
    m_prev_arm = arm;
  endtask

  task automatic check_model();
    check_output("m_ballot_led", ballot_led, m_phase == P_ARMED);
    check_output("m_busy", busy, m_phase == P_CAST || m_phase == P_BEEP);
    check_output("m_beep", beep, m_phase == P_BEEP);
    check_output("m_evm_en", evm_en, m_phase == P_CAST);
    check_output("m_evm_switch", evm_switch, (m_phase == P_CAST) ? m_cap : '0);
    check_output("m_reject", reject, m_rej);
    check_output("m_timeout", timeout, m_to);
    check_output("m_poll_closed", poll_closed, m_phase == P_CLOSED);
    check_output("m_disp_sel", disp_sel, (m_phase == P_CLOSED) ? (m_age / DISP_CYC) % N_CAND : 0);
    check_output("m_total_votes", total_votes, m_total);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (evm_en) begin
      en_count++;
      last_cast_sw = evm_switch;
    end
    if (reject) rej_count++;
    if (timeout) to_count++;
    check_model();
  endtask

  task automatic apply_stimulus(input logic a, input logic [N_CAND-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      arm = a;
      vote_sw = v;
      step();
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en0, rej0, to0;
    int k;
    logic [N_CAND-1:0] v;

    for (int i = 0; i < 14; i++) begin
      tbl[i] = '{arm: 1'b0, sw: '0, led: 1'b0, en: 1'b0, swo: '0, busy: 1'b0, bp: 1'b0, total: '0};
    end
    tbl[0].arm = 1'b1; tbl[0].led = 1'b1;
    for (int i = 1; i <= 6; i++) tbl[i].sw = 5'b00100;
    for (int i = 1; i <= 3; i++) tbl[i].led = 1'b1;
    tbl[4].en = 1'b1; tbl[4].swo = 5'b00100; tbl[4].busy = 1'b1;
    for (int i = 5; i <= 12; i++) begin
      tbl[i].busy = 1'b1; tbl[i].bp = 1'b1; tbl[i].total = 1;
    end
    tbl[13].total = 1;

    model_reset();
    #2;
    check_output("reset_evm_en", evm_en, 0);
    check_output("reset_ballot_led", ballot_led, 0);
    check_output("reset_total", total_votes, 0);
    check_model();
    #10 rst = 1'b1;

    // Single vote against the hand-written table.
    for (int i = 0; i < 14; i++) begin
      arm = tbl[i].arm;
      vote_sw = tbl[i].sw;
      step();
      check_output($sformatf("tbl%0d_led", i), ballot_led, tbl[i].led);
      check_output($sformatf("tbl%0d_en", i), evm_en, tbl[i].en);
      check_output($sformatf("tbl%0d_sw", i), evm_switch, tbl[i].swo);
      check_output($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check_output($sformatf("tbl%0d_beep", i), beep, tbl[i].bp);
      check_output($sformatf("tbl%0d_total", i), total_votes, tbl[i].total);
    end

    // Glitch, invalid press, no-release, then valid press.
    pulse_arm();
    en0 = en_count; rej0 = rej_count;
    apply_stimulus(0, 5'b00010, 2);
    apply_stimulus(0, 5'b00000, 1);
    apply_stimulus(0, 5'b00011, 4);
    check_output("glitch_reject_count", rej_count - rej0, 1);
    check_output("glitch_no_cast", en_count - en0, 0);
    apply_stimulus(0, 5'b01000, 6);
    check_output("noreleased_no_cast", en_count - en0, 0);
    check_output("noreleased_led", ballot_led, 1);
    apply_stimulus(0, 5'b00000, 1);
    apply_stimulus(0, 5'b01000, 4);
    check_output("valid_cast_en", evm_en, 1);
    apply_stimulus(0, 5'b00000, 10);
    check_output("valid_cast_count", en_count - en0, 1);
    check_output("valid_cast_sw", last_cast_sw, 5'b01000);
    check_output("valid_cast_total", total_votes, 2);
    check_output("valid_reject_total", rej_count - rej0, 1);

    // Timeout with no press, then re-arm.
    en0 = en_count; to0 = to_count;
    pulse_arm();
    apply_stimulus(0, 5'b00000, TIMEOUT_CYC + 5);
    check_output("timeout_count", to_count - to0, 1);
    check_output("timeout_no_cast", en_count - en0, 0);
    check_output("timeout_total", total_votes, 2);
    check_output("timeout_led", ballot_led, 0);
    pulse_arm();
    check_output("rearm_led", ballot_led, 1);

    // Sweep of every pattern for one cycle each, then a held press.
    en0 = en_count; rej0 = rej_count;
    for (int i = 0; i < 32; i++) apply_stimulus(0, 5'(i), 1);
    check_output("sweep_no_cast", en_count - en0, 0);
    check_output("sweep_no_reject", rej_count - rej0, 0);
    apply_stimulus(0, 5'b10000, 6);
    apply_stimulus(0, 5'b00000, 10);
    check_output("sweep_cast_count", en_count - en0, 1);
    check_output("sweep_cast_sw", last_cast_sw, 5'b10000);
    apply_stimulus(0, 5'b00001, 6);
    apply_stimulus(0, 5'b00000, 2);
    check_output("second_press_no_cast", en_count - en0, 1);
    check_output("sweep_total", total_votes, 3);

    // Randomized ballots checked by the model every cycle.
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 3) != 0) pulse_arm();
      k = 0;
      while (k < 40) begin
        case ($urandom_range(0, 2))
          0: v = '0;
          1: v = 5'(1 << $urandom_range(0, N_CAND - 1));
          default: v = 5'($urandom);
        endcase
        apply_stimulus(0, v, $urandom_range(1, 6));
        k = k + 6;
      end
      apply_stimulus(0, 5'b00000, BEEP_CYC + 3);
    end

    // Asynchronous reset with a half-debounced press.
    apply_stimulus(0, 5'b00000, 12);
    pulse_arm();
    apply_stimulus(0, 5'b00100, 2);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_output("async_rst_led", ballot_led, 0);
    check_output("async_rst_total", total_votes, 0);
    check_output("async_rst_en", evm_en, 0);
    check_model();
    @(negedge clk) rst = 1'b1;
    en0 = en_count;
    apply_stimulus(0, 5'b00100, 6);
    check_output("post_rst_no_cast", en_count - en0, 0);
    pulse_arm();
    apply_stimulus(0, 5'b00100, 5);
    apply_stimulus(0, 5'b00000, 10);
    check_output("post_rst_rearm_cast", en_count - en0, 1);
    check_output("post_rst_total", total_votes, 1);

    // Close request during BEEP, then display rotation.
    pulse_arm();
    apply_stimulus(0, 5'b00001, 4);
    apply_stimulus(0, 5'b00000, 1);
    check_output("close_in_beep", beep, 1);
    close_poll = 1'b1;
    apply_stimulus(0, 5'b00000, 1);
    close_poll = 1'b0;
    k = 0;
    while (beep && k < 20) begin
      apply_stimulus(0, 5'b00000, 1);
      k++;
    end
    check_output("beep_end_bound", beep, 0);
    check_output("closed_not_yet", poll_closed, 0);
    apply_stimulus(0, 5'b00000, 1);
    check_output("closed_rise", poll_closed, 1);
    check_output("disp_step0", disp_sel, 0);
    en0 = en_count;
    for (int s = 1; s <= 5; s++) begin
      for (int c = 0; c < DISP_CYC; c++) apply_stimulus(1'($urandom), 5'($urandom), 1);
      check_output($sformatf("disp_step%0d", s), disp_sel, s % N_CAND);
    end
    check_output("closed_no_cast", en_count - en0, 0);
    check_output("closed_led", ballot_led, 0);
    check_output("closed_total", total_votes, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
